irq_injector: RTL and testbench
===============================

// Module: irq_injector
// PURPOSE
//  Multi-channel external-interrupt stimulus generator for the P8 mips CPU bench and board top.
//  Each channel holds a target PC. When the CPU's macroscopic PC reaches a channel's target,
//  the block raises `interrupt` and holds it until the handler acknowledges with a store to
//  ACK_ADDR. Successor of the single-shot, single-PC bench injector: N channels,
//  runtime-programmable targets, repeat counts and an ack timeout.
// PARAMETERS
//  NCH        4             number of channels (1..16)
//  CW         2             channel index width, equal to $clog2(NCH) (min 1)
//  ACK_ADDR   32'h0000_7f20 word address whose store acknowledges the interrupt
//  MAX_FIRES  1             fires per channel before it retires (1..255)
//  TIMEOUT    1023          cycles of unacknowledged assertion before abort (needs IRQ_INJ_TIMEOUT_EN)
// PORTS
//  clk_in          in   1    system clock, all state on posedge
//  sys_rstn        in   1    asynchronous active-low reset
//  cfg_we          in   1    write channel config this cycle
//  cfg_ch          in   CW   channel written
//  cfg_pc          in   32   target PC; bits [1:0] ignored
//  cfg_en          in   1    1: arm channel, 0: disable channel
//  macroscopic_pc  in   32   CPU macroscopic PC; compared as pc & 32'hffff_fffc
//  m_int_addr      in   32   CPU M-stage data address
//  m_int_byteen    in   4    CPU M-stage store byte enables
//  interrupt       out  1    external interrupt line to the CPU (registered)
//  irq_vec         out  NCH  one-hot: channel currently asserting
//  done            out  NCH  sticky: channel completed MAX_FIRES acks
//  timeout_err     out  NCH  sticky: channel aborted on timeout
// BEHAVIOUR
//  Reset (sys_rstn=0, async): all channels IDLE, targets 0, fire counts 0; all outputs 0.
//  Per-channel FSM: IDLE, ARMED, ASSERT, COOL, DONE.
//   IDLE   -> ARMED on cfg write with cfg_en=1.
//   ARMED  -> ASSERT when fixed_pc==target and no channel is in ASSERT and the global line was
//             low last cycle. Lowest index wins if several match. interrupt/irq_vec go high the
//             cycle after the match (1-cycle latency).
//   ASSERT: ack = (|m_int_byteen) && ((m_int_addr & ~3)==ACK_ADDR). On ack, fire count
//           increments (8-bit). If count==MAX_FIRES -> DONE and done[i] is set; else -> COOL.
//           interrupt drops the cycle after ack.
//   COOL   -> ARMED once fixed_pc != target. This stops an immediate re-fire on the same PC.
//   DONE: terminal until cfg write.
//  Any cfg write to channel i moves it to ARMED (cfg_en=1) or IDLE (cfg_en=0), loads the target,
//  clears its fire count, done[i] and timeout_err[i]. If i was in ASSERT, interrupt drops the
//  next cycle. A cfg write beats ack/timeout/match for that channel in the same cycle.
//  interrupt == |irq_vec. At most one channel asserts. At least 1 low cycle separates
//  consecutive assertions, even when one ack and another channel's match share a cycle.
//  Stores to other addresses and loads (byteen=0) never acknowledge.
//  Ack seen while no channel asserts: ignored.
// CONFIGURATION
//  IRQ_INJ_TIMEOUT_EN defined:
//   - 10-bit timer counts ASSERT cycles.
//   - Reaching TIMEOUT without ack: channel -> DONE, timeout_err[i] set, done[i] not set,
//     interrupt drops next cycle.
//   - Ack and timeout in the same cycle: ack wins.
//  IRQ_INJ_TIMEOUT_EN undefined: no timer; ASSERT holds until ack or cfg write;
//   timeout_err tied 0.
// TESTING
//  1 reset: sys_rstn low mid-ASSERT -> interrupt, irq_vec, done=0 asynchronously;
//    no fire after release until reconfigured.
//  2 single shot: ch0 pc=0x3008, pc reaches 0x300a -> interrupt=1 next cycle;
//    store byteen=4'b0001 to 0x7f23 -> interrupt=0 next cycle, done=4'b0001.
//  3 priority: ch1 and ch2 both target 0x3100 -> irq_vec=4'b0010 first; after ack >=1 low cycle;
//    ch2 fires only when pc next equals 0x3100.
//  4 false ack: load to 0x7f20 (byteen=0) and store to 0x7f24 -> interrupt stays 1.
//  5 repeat: MAX_FIRES=2, loop revisits 0x3008 -> two assert/ack pairs, COOL between them;
//    done set after the 2nd ack only.
//  6 timeout (macro on, TIMEOUT=16): no ack -> interrupt high exactly 16 cycles,
//    timeout_err[0]=1, done[0]=0. Same cycle ack+timeout -> done[0]=1, timeout_err[0]=0.

Source files
------------

// File: rtl/irq_injector_if.sv
// rtl/irq_injector_if.sv - config, CPU-probe and interrupt signal bundle for irq_injector
interface irq_injector_if #(
    parameter int NCH = 4,
    parameter int CW  = 2
);
    logic           cfg_we;
    logic [CW-1:0]  cfg_ch;
    logic [31:0]    cfg_pc;
    logic           cfg_en;
    logic [31:0]    macroscopic_pc;
    logic [31:0]    m_int_addr;
    logic [3:0]     m_int_byteen;
    logic           interrupt;
    logic [NCH-1:0] irq_vec;
    logic [NCH-1:0] done;
    logic [NCH-1:0] timeout_err;

    modport master (
        output cfg_we, cfg_ch, cfg_pc, cfg_en, macroscopic_pc, m_int_addr, m_int_byteen,
        input  interrupt, irq_vec, done, timeout_err
    );
    modport slave (
        input  cfg_we, cfg_ch, cfg_pc, cfg_en, macroscopic_pc, m_int_addr, m_int_byteen,
        output interrupt, irq_vec, done, timeout_err
    );
endinterface

// File: rtl/irq_injector.sv
// rtl/irq_injector.sv - multi-channel PC-triggered interrupt injector with store-to-address ack
// Optional ack timeout enabled by defining IRQ_INJ_TIMEOUT_EN.
module irq_injector #(
    parameter int          NCH       = 4,
    parameter int          CW        = 2,
    parameter logic [31:0] ACK_ADDR  = 32'h0000_7f20,
    parameter int          MAX_FIRES = 1,
    parameter int          TIMEOUT   = 1023
) (
    input logic          clk_in,
    input logic          sys_rstn,
    irq_injector_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_ASSERT, S_COOL, S_DONE} state_t;

    state_t         state_q  [NCH];
    state_t         state_d  [NCH];
    logic [31:0]    target_q [NCH];
    logic [31:0]    target_d [NCH];
    logic [7:0]     cnt_q    [NCH];
    logic [7:0]     cnt_d    [NCH];
    logic [NCH-1:0] done_q, done_d, terr_q, terr_d;
    logic           irq_prev_q;

    logic [31:0]    fixed_pc;
    logic           ack;
    logic           any_assert;
    logic           can_fire;
    logic           timeout_hit;
    logic           found;
    logic [NCH-1:0] cfg_hit, match_vec, grant, irq_vec;

    assign fixed_pc = bus.macroscopic_pc & 32'hffff_fffc;
    assign ack      = (|bus.m_int_byteen) && ((bus.m_int_addr & 32'hffff_fffc) == ACK_ADDR);
    assign any_assert = |irq_vec;
    // Requiring the line low for a full cycle guarantees a gap between back-to-back channels.
    assign can_fire = !any_assert && !irq_prev_q;

`ifdef IRQ_INJ_TIMEOUT_EN
    logic [9:0] timer_q, timer_d;
    assign timer_d     = any_assert ? timer_q + 10'd1 : 10'd0;
    assign timeout_hit = (timer_q == 10'(TIMEOUT - 1));
    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) timer_q <= 10'd0;
        else           timer_q <= timer_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        cfg_hit   = '0;
        match_vec = '0;
        irq_vec   = '0;
        for (int i = 0; i < NCH; i++) begin
            cfg_hit[i]   = bus.cfg_we && (bus.cfg_ch == CW'(i));
            irq_vec[i]   = (state_q[i] == S_ASSERT);
            match_vec[i] = (state_q[i] == S_ARMED) && (fixed_pc == target_q[i]) && !cfg_hit[i];
        end
    end

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (match_vec[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        done_d = done_q;
        terr_d = terr_q;
        for (int i = 0; i < NCH; i++) begin
            state_d[i]  = state_q[i];
            target_d[i] = target_q[i];
            cnt_d[i]    = cnt_q[i];
            if (cfg_hit[i]) begin
                state_d[i]  = bus.cfg_en ? S_ARMED : S_IDLE;
                target_d[i] = bus.cfg_pc & 32'hffff_fffc;
                cnt_d[i]    = 8'd0;
                done_d[i]   = 1'b0;
                terr_d[i]   = 1'b0;
            end else begin
                case (state_q[i])
                    S_ARMED: if (can_fire && grant[i]) state_d[i] = S_ASSERT;
                    S_ASSERT: begin
                        if (ack) begin
                            cnt_d[i] = cnt_q[i] + 8'd1;
                            if (cnt_q[i] + 8'd1 == 8'(MAX_FIRES)) begin
                                state_d[i] = S_DONE;
                                done_d[i]  = 1'b1;
                            end else begin
                                state_d[i] = S_COOL;
                            end
                        end else if (timeout_hit) begin
                            state_d[i] = S_DONE;
                            terr_d[i]  = 1'b1;
                        end
                    end
                    S_COOL:  if (fixed_pc != target_q[i]) state_d[i] = S_ARMED;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge sys_rstn) begin
        if (!sys_rstn) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= S_IDLE;
                target_q[i] <= 32'd0;
                cnt_q[i]    <= 8'd0;
            end
            done_q     <= '0;
            terr_q     <= '0;
            irq_prev_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= state_d[i];
                target_q[i] <= target_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            done_q     <= done_d;
            terr_q     <= terr_d;
            irq_prev_q <= any_assert;
        end
    end

    assign bus.irq_vec     = irq_vec;
    assign bus.interrupt   = any_assert;
    assign bus.done        = done_q;
    assign bus.timeout_err = terr_q;
endmodule

// File: tb/tb_irq_injector.sv
// tb/tb_irq_injector.sv - directed bench for irq_injector (MAX_FIRES=1 and MAX_FIRES=2 instances)
module tb_irq_injector;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   vectors = 0;
    int   errs = 0;
    int   hi_cnt;

    always #5 clk = ~clk;

    irq_injector_if #(.NCH(4), .CW(2)) ba ();
    irq_injector_if #(.NCH(4), .CW(2)) bb ();

    irq_injector #(.NCH(4), .CW(2), .MAX_FIRES(1), .TIMEOUT(16)) dut_a (
        .clk_in(clk), .sys_rstn(rstn), .bus(ba.slave));
    irq_injector #(.NCH(4), .CW(2), .MAX_FIRES(2), .TIMEOUT(16)) dut_b (
        .clk_in(clk), .sys_rstn(rstn), .bus(bb.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cfg_a(input logic [1:0] ch, input logic [31:0] pc, input logic en);
        ba.cfg_we = 1'b1; ba.cfg_ch = ch; ba.cfg_pc = pc; ba.cfg_en = en;
        tick();
        ba.cfg_we = 1'b0;
    endtask

    task automatic ack_a(input logic [31:0] addr, input logic [3:0] be);
        ba.m_int_addr = addr; ba.m_int_byteen = be;
        tick();
        ba.m_int_byteen = 4'b0000;
    endtask

    initial begin
        ba.cfg_we = 0; ba.cfg_ch = 0; ba.cfg_pc = 0; ba.cfg_en = 0;
        ba.macroscopic_pc = 32'h2000; ba.m_int_addr = 0; ba.m_int_byteen = 0;
        bb.cfg_we = 0; bb.cfg_ch = 0; bb.cfg_pc = 0; bb.cfg_en = 0;
        bb.macroscopic_pc = 32'h2000; bb.m_int_addr = 0; bb.m_int_byteen = 0;
        tick(); tick();
        chk("reset_int", {31'd0, ba.interrupt}, 32'd0);
        chk("reset_vec", {28'd0, ba.irq_vec}, 32'd0);
        chk("reset_done", {28'd0, ba.done}, 32'd0);
        rstn = 1'b1;
        tick();

        // single shot with false acks in between
        cfg_a(2'd0, 32'h3008, 1'b1);
        ba.macroscopic_pc = 32'h300a;
        tick();
        chk("single_fire_int", {31'd0, ba.interrupt}, 32'd1);
        chk("single_fire_vec", {28'd0, ba.irq_vec}, 32'h1);
        ack_a(32'h7f20, 4'b0000);
        chk("false_ack_load", {31'd0, ba.interrupt}, 32'd1);
        ack_a(32'h7f24, 4'b1111);
        chk("false_ack_addr", {31'd0, ba.interrupt}, 32'd1);
        ack_a(32'h7f23, 4'b0001);
        chk("single_ack_int", {31'd0, ba.interrupt}, 32'd0);
        chk("single_done", {28'd0, ba.done}, 32'h1);
        tick();
        chk("single_no_refire", {31'd0, ba.interrupt}, 32'd0);
        ack_a(32'h7f20, 4'b1111);
        chk("stray_ack_ignored", {31'd0, ba.interrupt}, 32'd0);

        // priority: ch1 and ch2 share a target
        ba.macroscopic_pc = 32'h2000;
        cfg_a(2'd1, 32'h3100, 1'b1);
        cfg_a(2'd2, 32'h3100, 1'b1);
        ba.macroscopic_pc = 32'h3100;
        tick();
        chk("prio_vec", {28'd0, ba.irq_vec}, 32'h2);
        ba.macroscopic_pc = 32'h2000;
        ack_a(32'h7f20, 4'b1000);
        chk("prio_gap_int", {31'd0, ba.interrupt}, 32'd0);
        chk("prio_done", {28'd0, ba.done}, 32'h3);
        tick();
        chk("prio_away_int", {31'd0, ba.interrupt}, 32'd0);
        ba.macroscopic_pc = 32'h3100;
        tick();
        chk("prio_second_vec", {28'd0, ba.irq_vec}, 32'h4);

        // async reset mid-assert
        rstn = 1'b0;
        #1;
        chk("async_rst_int", {31'd0, ba.interrupt}, 32'd0);
        chk("async_rst_vec", {28'd0, ba.irq_vec}, 32'd0);
        chk("async_rst_done", {28'd0, ba.done}, 32'd0);
        tick();
        rstn = 1'b1;
        ba.macroscopic_pc = 32'h0;
        tick(); tick();
        chk("post_rst_pc0", {31'd0, ba.interrupt}, 32'd0);
        ba.macroscopic_pc = 32'h3100;
        tick(); tick();
        chk("post_rst_nofire", {31'd0, ba.interrupt}, 32'd0);

        // repeat fires on the MAX_FIRES=2 instance
        bb.cfg_we = 1; bb.cfg_ch = 2'd0; bb.cfg_pc = 32'h3008; bb.cfg_en = 1;
        tick();
        bb.cfg_we = 0;
        bb.macroscopic_pc = 32'h3008;
        tick();
        chk("rep_fire1", {31'd0, bb.interrupt}, 32'd1);
        bb.m_int_addr = 32'h7f20; bb.m_int_byteen = 4'b0011;
        tick();
        bb.m_int_byteen = 0;
        chk("rep_ack1_int", {31'd0, bb.interrupt}, 32'd0);
        chk("rep_ack1_done", {28'd0, bb.done}, 32'd0);
        tick(); tick();
        chk("rep_cool_hold", {31'd0, bb.interrupt}, 32'd0);
        bb.macroscopic_pc = 32'h300c;
        tick();
        chk("rep_leave_pc", {31'd0, bb.interrupt}, 32'd0);
        bb.macroscopic_pc = 32'h3008;
        tick();
        chk("rep_fire2", {31'd0, bb.interrupt}, 32'd1);
        bb.m_int_byteen = 4'b0100;
        tick();
        bb.m_int_byteen = 0;
        chk("rep_ack2_int", {31'd0, bb.interrupt}, 32'd0);
        chk("rep_ack2_done", {28'd0, bb.done}, 32'h1);

        // timeout behaviour on ch3 of the first instance
        ba.macroscopic_pc = 32'h2000;
        cfg_a(2'd3, 32'h4000, 1'b1);
        ba.macroscopic_pc = 32'h4000;
        tick();
        hi_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (ba.interrupt) hi_cnt++;
            tick();
        end
`ifdef IRQ_INJ_TIMEOUT_EN
        chk("to_high_cycles", hi_cnt, 32'd16);
        chk("to_err", {28'd0, ba.timeout_err}, 32'h8);
        chk("to_done", {28'd0, ba.done}, 32'd0);
        ba.macroscopic_pc = 32'h2000;
        cfg_a(2'd3, 32'h4000, 1'b1);
        chk("to_cfg_clear", {28'd0, ba.timeout_err}, 32'd0);
        ba.macroscopic_pc = 32'h4000;
        tick();
        for (int k = 0; k < 15; k++) tick();
        chk("to_still_high", {31'd0, ba.interrupt}, 32'd1);
        ack_a(32'h7f20, 4'b0001);
        chk("to_ack_done", {28'd0, ba.done}, 32'h8);
        chk("to_ack_err", {28'd0, ba.timeout_err}, 32'd0);
        chk("to_ack_int", {31'd0, ba.interrupt}, 32'd0);
`else
        chk("noto_high_cycles", hi_cnt, 32'd40);
        chk("noto_err", {28'd0, ba.timeout_err}, 32'd0);
        cfg_a(2'd3, 32'h5000, 1'b0);
        chk("noto_cfg_drop", {31'd0, ba.interrupt}, 32'd0);
        chk("noto_done", {28'd0, ba.done}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
